// File: rtl/ds1302_pkg.sv
// rtl/ds1302_pkg.sv - shared constants, state encoding and command decode for the DS1302 responder
package ds1302_pkg;

    localparam int CMD_RD_BIT    = 0;
    localparam int CMD_RAM_BIT   = 6;
    localparam int CMD_VALID_BIT = 7;

    localparam logic [2:0] SEC   = 3'd0;
    localparam logic [2:0] MIN   = 3'd1;
    localparam logic [2:0] HOUR  = 3'd2;
    localparam logic [2:0] DATE  = 3'd3;
    localparam logic [2:0] MONTH = 3'd4;
    localparam logic [2:0] DAY   = 3'd5;
    localparam logic [2:0] YEAR  = 3'd6;
    localparam logic [2:0] WP    = 3'd7;

    localparam logic [7:0] SEC_RST   = 8'h80;
    localparam logic [7:0] MIN_RST   = 8'h00;
    localparam logic [7:0] HOUR_RST  = 8'h00;
    localparam logic [7:0] DATE_RST  = 8'h01;
    localparam logic [7:0] MONTH_RST = 8'h01;
    localparam logic [7:0] DAY_RST   = 8'h01;
    localparam logic [7:0] YEAR_RST  = 8'h00;
    localparam logic [7:0] WP_RST    = 8'h00;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_RDATA,
        ST_WDATA,
        ST_DONE
    } state_t;

    function automatic logic [7:0] reg_reset(input logic [2:0] idx);
        case (idx)
            SEC:     return SEC_RST;
            MIN:     return MIN_RST;
            HOUR:    return HOUR_RST;
            DATE:    return DATE_RST;
            MONTH:   return MONTH_RST;
            DAY:     return DAY_RST;
            YEAR:    return YEAR_RST;
            default: return WP_RST;
        endcase
    endfunction

    // Takes cmd[7:4]: marker bit set, clock (not RAM) space, address bits 5:4 zero
    function automatic logic cmd_ok(input logic [3:0] hi);
        return hi[CMD_VALID_BIT-4] && !hi[CMD_RAM_BIT-4] && (hi[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/ds1302_responder_bcd_inc.sv
// rtl/ds1302_responder_bcd_inc.sv - two-digit BCD increment that wraps to zero at MAX
module bcd_inc #(
    parameter logic [7:0] MAX = 8'h59
) (
    input  logic [7:0] val,
    output logic [7:0] nxt,
    output logic       carry
);

    always_comb begin
        nxt   = val;
        carry = 1'b0;
        if (val == MAX) begin
            nxt   = 8'h00;
            carry = 1'b1;
        end else if (val[3:0] >= 4'd9) begin
            nxt = {val[7:4] + 4'd1, 4'd0};
        end else begin
            nxt = {val[7:4], val[3:0] + 4'd1};
        end
    end

endmodule

// File: rtl/ds1302_responder.sv
// rtl/ds1302_responder.sv - device-side DS1302 model: serial register access plus BCD timekeeper
module ds1302_responder
    import ds1302_pkg::*;
#(
    parameter int CLK_FRE  = 50,
    parameter int TICK_DIV = CLK_FRE * 1_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ce,
    input  logic       sck,
    input  logic       dat_in,
    output logic       dat_out,
    output logic       dat_oe,
    output logic [7:0] sec_bcd,
    output logic [7:0] min_bcd,
    output logic [7:0] hou_bcd
);

    logic ce_s1, ce_s2, ce_s3;
    logic sck_s1, sck_s2, sck_s3;
    logic dat_s1, dat_s2;

    always_ff @(posedge clk) begin
        if (rst) begin
            {ce_s1, ce_s2, ce_s3}    <= 3'b000;
            {sck_s1, sck_s2, sck_s3} <= 3'b000;
            {dat_s1, dat_s2}         <= 2'b00;
        end else begin
            {ce_s1, ce_s2, ce_s3}    <= {ce, ce_s1, ce_s2};
            {sck_s1, sck_s2, sck_s3} <= {sck, sck_s1, sck_s2};
            {dat_s1, dat_s2}         <= {dat_in, dat_s1};
        end
    end

    logic sck_rise, sck_fall, ce_rise;
    assign sck_rise = sck_s2 & ~sck_s3;
    assign sck_fall = ~sck_s2 & sck_s3;
    assign ce_rise  = ce_s2 & ~ce_s3;

    logic [7:0] regs [8];
    state_t     state;
    logic [3:0] bit_cnt;
    logic [7:0] shreg;
    logic [7:0] shift_in;
    logic       cmd_ok_q;
    logic [2:0] cmd_idx_q;
    logic       wr_en;
    logic [2:0] wr_addr;
    logic [7:0] wr_data;

    assign shift_in = {dat_s2, shreg[7:1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            bit_cnt   <= 4'd0;
            shreg     <= 8'h00;
            cmd_ok_q  <= 1'b0;
            cmd_idx_q <= 3'd0;
            dat_out   <= 1'b0;
            dat_oe    <= 1'b0;
            wr_en     <= 1'b0;
            wr_addr   <= 3'd0;
            wr_data   <= 8'h00;
        end else begin
            wr_en <= 1'b0;
            if (!ce_s2) begin
                state   <= ST_IDLE;
                dat_oe  <= 1'b0;
                dat_out <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (ce_rise) begin
                            bit_cnt <= 4'd0;
                            state   <= ST_CMD;
                        end
                    end
                    ST_CMD: begin
                        if (sck_rise) begin
                            shreg <= shift_in;
                            if (bit_cnt == 4'd7) begin
                                bit_cnt   <= 4'd0;
                                cmd_ok_q  <= cmd_ok(shift_in[7:4]);
                                cmd_idx_q <= shift_in[3:1];
                                if (shift_in[CMD_RD_BIT]) begin
                                    shreg <= cmd_ok(shift_in[7:4]) ? regs[shift_in[3:1]] : 8'h00;
                                    state <= ST_RDATA;
                                end else begin
                                    state <= ST_WDATA;
                                end
                            end else begin
                                bit_cnt <= bit_cnt + 4'd1;
                            end
                        end
                    end
                    ST_RDATA: begin
                        // Eight falls drive bits 0..7; the ninth releases the pin
                        if (sck_fall) begin
                            if (bit_cnt == 4'd8) begin
                                state   <= ST_DONE;
                                dat_oe  <= 1'b0;
                                dat_out <= 1'b0;
                            end else begin
                                dat_out <= shreg[0];
                                dat_oe  <= 1'b1;
                                shreg   <= {1'b0, shreg[7:1]};
                                bit_cnt <= bit_cnt + 4'd1;
                            end
                        end
                    end
                    ST_WDATA: begin
                        if (sck_rise) begin
                            shreg <= shift_in;
                            if (bit_cnt == 4'd7) begin
                                wr_en   <= cmd_ok_q && (!regs[WP][7] || cmd_idx_q == WP);
                                wr_addr <= cmd_idx_q;
                                wr_data <= shift_in;
                                state   <= ST_DONE;
                            end else begin
                                bit_cnt <= bit_cnt + 4'd1;
                            end
                        end
                    end
                    ST_DONE: begin
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    logic [31:0] presc;
    logic        running, tick;
    logic [7:0]  sec_nx, min_nx, hou_nx;
    logic        sec_c, min_c, hou_c;

    assign running = ~regs[SEC][7];
    assign tick    = running && (presc == 32'(TICK_DIV - 1));

    bcd_inc #(.MAX(8'h59)) u_sec (.val({1'b0, regs[SEC][6:0]}),  .nxt(sec_nx), .carry(sec_c));
    bcd_inc #(.MAX(8'h59)) u_min (.val({1'b0, regs[MIN][6:0]}),  .nxt(min_nx), .carry(min_c));
    bcd_inc #(.MAX(8'h23)) u_hou (.val({1'b0, regs[HOUR][6:0]}), .nxt(hou_nx), .carry(hou_c));

    // The write is applied after the tick so it wins on the register it names
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) regs[i] <= reg_reset(3'(i));
            presc <= 32'd0;
        end else begin
            if (running) presc <= tick ? 32'd0 : presc + 32'd1;
            if (tick) begin
                regs[SEC] <= sec_nx;
                if (sec_c) regs[MIN] <= min_nx;
                if (sec_c && min_c) regs[HOUR] <= {regs[HOUR][7], hou_nx[6:0]};
            end
            if (wr_en) begin
                regs[wr_addr] <= wr_data;
                if (wr_addr == SEC) presc <= 32'd0;
            end
        end
    end

    logic unused_hou_c;
    assign unused_hou_c = hou_c;

    assign sec_bcd = regs[SEC];
    assign min_bcd = regs[MIN];
    assign hou_bcd = regs[HOUR];

endmodule
